// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset datapath: PC, IR, MDR, A, B, ALUOut, a 32x32
// register file, the ALU and its operand muxes, and the unified memory port.
// Every control strobe comes from the multicycle controller; opcode and zero
// go back to it.
module multicycle_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alusrcA,
    input  logic [1:0]  alusrcB,
    input  logic [1:0]  toaluctrl,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        regwrite,
    input  logic        pc_write,
    input  logic        pc_write_condition_beq,
    input  logic        pc_write_condition_bne,
    input  logic        IorD,
    input  logic        IR_write,
    input  logic [1:0]  pcsrc,
    input  logic [1:0]  regdst,
    input  logic [1:0]  memtoreg,
    output logic [5:0]  opcode,
    output logic        zero,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_read,
    output logic        mem_write
);

    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    // Architectural and inter-cycle state
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] aluout;
    logic [31:0] rf [32];

    // Instruction fields
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] jtarget;

    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign funct   = ir[5:0];
    assign imm16   = ir[15:0];
    assign jtarget = ir[25:0];

    // Immediates: andi zero-extends, every other I-type sign-extends
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] imm_itype;

    assign imm_sext  = {{16{imm16[15]}}, imm16};
    assign imm_zext  = {16'h0000, imm16};
    assign imm_itype = (opcode == OP_ANDI) ? imm_zext : imm_sext;

    // Asynchronous register file reads; register 0 always reads as zero
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    assign rs_data = (rs == 5'd0) ? 32'd0 : rf[rs];
    assign rt_data = (rt == 5'd0) ? 32'd0 : rf[rt];

    // ALU datapath signals
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    alu_op_e     alu_op;
    logic [31:0] alu_result;

    // Operand selection; alusrcB=01 doubles as +4 (PC side) or the I-type immediate (A side)
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alu_a = alusrcA ? a_reg : pc;
        alu_b = b_reg;
        case (alusrcB)
            2'b00:   alu_b = b_reg;
            2'b01:   alu_b = alusrcA ? imm_itype : 32'd4;
            2'b10:   alu_b = imm_sext;
            default: alu_b = {imm_sext[29:0], 2'b00};
        endcase
    end

    // ALU operation: direct classes, or funct decode for R-type (unknown funct falls back to add)
    always_comb begin
        alu_op = ALU_ADD;
        case (toaluctrl)
            2'b00: alu_op = ALU_ADD;
            2'b01: alu_op = ALU_SUB;
            2'b11: alu_op = ALU_AND;
            default: begin
                case (funct)
                    FUNCT_ADD: alu_op = ALU_ADD;
                    FUNCT_SUB: alu_op = ALU_SUB;
                    FUNCT_AND: alu_op = ALU_AND;
                    FUNCT_OR:  alu_op = ALU_OR;
                    FUNCT_SLT: alu_op = ALU_SLT;
                    default:   alu_op = ALU_ADD;
                endcase
            end
        endcase
    end

    // 32-bit wrap-around ALU; slt is a signed comparison
    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_SLT: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_result = alu_a + alu_b;
        endcase
    end

    // zero comes from this cycle's ALU result so branches resolve in the same cycle
    assign zero = (alu_result == 32'd0);

    // Next-PC selection and write enable
    logic [31:0] next_pc;
    logic        pc_en;

    // Next PC: ALU (PC+4), jump target, branch target held in ALUOut, or A for jr
    always_comb begin
        next_pc = alu_result;
        case (pcsrc)
            2'b00:   next_pc = alu_result;
            2'b01:   next_pc = {pc[31:28], jtarget, 2'b00};
            2'b10:   next_pc = aluout;
            default: next_pc = a_reg;
        endcase
    end

    assign pc_en = pc_write
                 | (pc_write_condition_beq &  zero)
                 | (pc_write_condition_bne & ~zero);

    // Register write-back selection
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;

    // Write destination (rt, rd, or $ra) and data (ALUOut, MDR, or PC for jal)
    always_comb begin
        wr_reg  = rt;
        wr_data = aluout;
        case (regdst)
            2'b01:   wr_reg = rd;
            2'b10:   wr_reg = 5'd31;
            default: wr_reg = rt;
        endcase
        case (memtoreg)
            2'b01:   wr_data = mdr;
            2'b10:   wr_data = pc;
            default: wr_data = aluout;
        endcase
    end

    // Inter-cycle latches every cycle; PC and IR only on their enables; reset wins over all
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here make A/B sample the register file as it was before this edge's write.
        if (reset) begin
            pc     <= RESET_PC;
            ir     <= 32'd0;
            mdr    <= 32'd0;
            a_reg  <= 32'd0;
            b_reg  <= 32'd0;
            aluout <= 32'd0;
        end else begin
            mdr    <= mem_rdata;
            a_reg  <= rs_data;
            b_reg  <= rt_data;
            aluout <= alu_result;
            if (IR_write) begin
                ir <= mem_rdata;
            end
            if (pc_en) begin
                pc <= next_pc;
            end
        end
    end

    // Register file write port; register 0 is never written
    always_ff @(posedge clk) begin
        // NOTE: the register file is cleared on reset, so it maps to flops rather than a RAM macro.
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= 32'd0;
            end
        end else if (regwrite && (wr_reg != 5'd0)) begin
            rf[wr_reg] <= wr_data;
        end
    end

    // Memory port and controller feedback
    assign opcode    = ir[31:26];
    assign mem_addr  = IorD ? aluout : pc;
    assign mem_wdata = b_reg;
    assign mem_read  = memread;
    assign mem_write = memwrite;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath: directed instruction sequences
// followed by random control/memory traffic, all compared each cycle against an
// instruction-level reference model of the datapath state.
module tb_multicycle_datapath;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic       rst;
        logic       alusrc_a;
        logic [1:0] alusrc_b;
        logic [1:0] aluctrl;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       pc_write;
        logic       beq;
        logic       bne;
        logic       iord;
        logic       ir_write;
        logic [1:0] pcsrc;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
    } ctrl_t;

    logic        clk;
    logic        reset;
    logic        alusrcA;
    logic [1:0]  alusrcB;
    logic [1:0]  toaluctrl;
    logic        memread;
    logic        memwrite;
    logic        regwrite;
    logic        pc_write;
    logic        pc_write_condition_beq;
    logic        pc_write_condition_bne;
    logic        IorD;
    logic        IR_write;
    logic [1:0]  pcsrc;
    logic [1:0]  regdst;
    logic [1:0]  memtoreg;
    logic [5:0]  opcode;
    logic        zero;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;

    multicycle_datapath #(.RESET_PC(RESET_PC)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .alusrcA                (alusrcA),
        .alusrcB                (alusrcB),
        .toaluctrl              (toaluctrl),
        .memread                (memread),
        .memwrite               (memwrite),
        .regwrite               (regwrite),
        .pc_write               (pc_write),
        .pc_write_condition_beq (pc_write_condition_beq),
        .pc_write_condition_bne (pc_write_condition_bne),
        .IorD                   (IorD),
        .IR_write               (IR_write),
        .pcsrc                  (pcsrc),
        .regdst                 (regdst),
        .memtoreg               (memtoreg),
        .opcode                 (opcode),
        .zero                   (zero),
        .mem_addr               (mem_addr),
        .mem_wdata              (mem_wdata),
        .mem_rdata              (mem_rdata),
        .mem_read               (mem_read),
        .mem_write              (mem_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Reference model state
    logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;
    logic [31:0] m_rf [32];
    bit          m_valid;
    ctrl_t       cur;
    logic [31:0] cur_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic ctrl_t idle();
        ctrl_t c;
        c = '0;
        return c;
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // ALU result for the current control word, from the instruction-level rules
    function automatic logic [31:0] m_alu();
        logic [31:0] x;
        logic [31:0] y;
        x = cur.alusrc_a ? m_a : m_pc;
        case (cur.alusrc_b)
            2'b00: y = m_b;
            2'b01: begin
                if (!cur.alusrc_a)                y = 32'd4;
                else if (m_ir[31:26] == 6'h0C)    y = {16'h0000, m_ir[15:0]};
                else                              y = sext16(m_ir[15:0]);
            end
            2'b10: y = sext16(m_ir[15:0]);
            default: y = sext16(m_ir[15:0]) * 4;
        endcase
        case (cur.aluctrl)
            2'b00: return x + y;
            2'b01: return x - y;
            2'b11: return x & y;
            default: begin
                case (m_ir[5:0])
                    6'h22:   return x - y;
                    6'h24:   return x & y;
                    6'h25:   return x | y;
                    6'h2A:   return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                    default: return x + y;
                endcase
            end
        endcase
    endfunction

    task automatic check_outputs();
        if (m_valid) begin
            check("opcode",    32'(opcode),    32'(m_ir[31:26]));
            check("zero",      32'(zero),      32'(m_alu() == 32'd0));
            check("mem_addr",  mem_addr,       cur.iord ? m_aluout : m_pc);
            check("mem_wdata", mem_wdata,      m_b);
            check("mem_read",  32'(mem_read),  32'(cur.memread));
            check("mem_write", 32'(mem_write), 32'(cur.memwrite));
        end
    endtask

    // Advance the model by one clock edge under the current control word
    task automatic model_step();
        logic [31:0] res, npc, wd;
        logic [4:0]  wr;
        logic        take;
        if (cur.rst) begin
            m_pc = RESET_PC; m_ir = '0; m_mdr = '0; m_a = '0; m_b = '0; m_aluout = '0;
            for (int i = 0; i < 32; i++) m_rf[i] = '0;
            m_valid = 1'b1;
            return;
        end
        res = m_alu();
        case (cur.pcsrc)
            2'b00:   npc = res;
            2'b01:   npc = {m_pc[31:28], m_ir[25:0], 2'b00};
            2'b10:   npc = m_aluout;
            default: npc = m_a;
        endcase
        take = cur.pc_write || (cur.beq && res == 0) || (cur.bne && res != 0);
        wr = (cur.regdst == 2'b01) ? m_ir[15:11] : (cur.regdst == 2'b10) ? 5'd31 : m_ir[20:16];
        wd = (cur.memtoreg == 2'b01) ? m_mdr : (cur.memtoreg == 2'b10) ? m_pc : m_aluout;
        m_a = m_rf[m_ir[25:21]];
        m_b = m_rf[m_ir[20:16]];
        if (cur.regwrite && wr != 5'd0) m_rf[wr] = wd;
        m_mdr    = cur_rdata;
        m_aluout = res;
        if (cur.ir_write) m_ir = cur_rdata;
        if (take) m_pc = npc;
    endtask

    task automatic apply(input ctrl_t c, input logic [31:0] rdata);
        cur       = c;
        cur_rdata = rdata;
        reset                  = c.rst;
        alusrcA                = c.alusrc_a;
        alusrcB                = c.alusrc_b;
        toaluctrl              = c.aluctrl;
        memread                = c.memread;
        memwrite               = c.memwrite;
        regwrite               = c.regwrite;
        pc_write               = c.pc_write;
        pc_write_condition_beq = c.beq;
        pc_write_condition_bne = c.bne;
        IorD                   = c.iord;
        IR_write               = c.ir_write;
        pcsrc                  = c.pcsrc;
        regdst                 = c.regdst;
        memtoreg               = c.memtoreg;
        mem_rdata              = rdata;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Load IR, then one more cycle so A/B hold its rs/rt registers
    task automatic load_ir(input logic [31:0] instr);
        ctrl_t c;
        c = idle(); c.ir_write = 1'b1;
        apply(c, instr); tick();
        apply(idle(), 32'd0); tick();
    endtask

    // Write a register through the MDR path (lw write-back)
    task automatic set_reg(input logic [4:0] r, input logic [31:0] val);
        ctrl_t c;
        c = idle(); c.ir_write = 1'b1;
        apply(c, itype(6'h23, 5'd0, r, 16'h0000)); tick();
        apply(idle(), val); tick();
        c = idle(); c.regwrite = 1'b1; c.memtoreg = 2'b01;
        apply(c, 32'd0); tick();
    endtask

    task automatic read_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
        load_ir(itype(6'h23, 5'd0, r, 16'h0000));
        check(tag, mem_wdata, exp);
    endtask

    task automatic peek_pc(input string tag, input logic [31:0] exp);
        apply(idle(), 32'd0);
        check(tag, mem_addr, exp);
    endtask

    task automatic peek_aluout(input string tag, input logic [31:0] exp);
        ctrl_t c;
        c = idle(); c.iord = 1'b1;
        apply(c, 32'd0);
        check(tag, mem_addr, exp);
    endtask

    // jr through register 12
    task automatic set_pc(input logic [31:0] val);
        ctrl_t c;
        set_reg(5'd12, val);
        load_ir(rtype(5'd12, 5'd0, 5'd0, 6'h08));
        c = idle(); c.pc_write = 1'b1; c.pcsrc = 2'b11;
        apply(c, 32'd0); tick();
    endtask

    // Execute an ALU instruction and write ALUOut back to the register file
    task automatic exec_rf(input logic [31:0] instr, input logic asa, input logic [1:0] asb,
                           input logic [1:0] actl, input logic [1:0] rdst);
        ctrl_t c;
        load_ir(instr);
        c = idle(); c.alusrc_a = asa; c.alusrc_b = asb; c.aluctrl = actl;
        apply(c, 32'd0); tick();
        c = idle(); c.regwrite = 1'b1; c.regdst = rdst;
        apply(c, 32'd0); tick();
    endtask

    // From PC=4, target = 4 + 0x3F*4 = 0x100 in ALUOut, then compare rs/rt
    task automatic branch(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                          input logic beq, input logic bne, input logic exp_zero,
                          input logic [31:0] exp_pc);
        ctrl_t c;
        set_pc(32'd4);
        load_ir(itype(6'h04, rs, rt, 16'h003F));
        c = idle(); c.alusrc_b = 2'b11;
        apply(c, 32'd0); tick();
        peek_aluout({tag, "_target"}, 32'h0000_0100);
        c = idle(); c.alusrc_a = 1'b1; c.aluctrl = 2'b01; c.beq = beq; c.bne = bne; c.pcsrc = 2'b10;
        apply(c, 32'd0);
        check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
        tick();
        peek_pc({tag, "_pc"}, exp_pc);
    endtask

    initial begin
        ctrl_t c;
        n_checks = 0;
        n_fail   = 0;
        m_valid  = 1'b0;

        // Reset
        c = idle(); c.rst = 1'b1;
        apply(c, 32'd0);
        @(posedge clk); #1;
        apply(c, 32'd0); tick();
        apply(idle(), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_zero",   32'(zero),   32'd1);
        check("rst_pc",     mem_addr,    RESET_PC);
        check("rst_b",      mem_wdata,   32'd0);

        // Fetch addi $8,$0,5
        c = idle(); c.ir_write = 1'b1; c.alusrc_b = 2'b01; c.pc_write = 1'b1; c.memread = 1'b1;
        apply(c, 32'h2008_0005);
        check("fetch_addr",     mem_addr,        32'd0);
        check("fetch_mem_read", 32'(mem_read),   32'd1);
        tick();
        peek_pc("fetch_pc", 32'd4);
        check("fetch_opcode", 32'(opcode), 32'h0000_0008);

        // andi zero-extends, addi sign-extends
        set_reg(5'd9, 32'h0000_FFFF);
        exec_rf(itype(6'h0C, 5'd9, 5'd10, 16'h8001), 1'b1, 2'b01, 2'b11, 2'b00);
        read_reg("andi_zext", 5'd10, 32'h0000_8001);
        exec_rf(itype(6'h08, 5'd9, 5'd10, 16'hFFFF), 1'b1, 2'b01, 2'b00, 2'b00);
        read_reg("addi_sext", 5'd10, 32'h0000_FFFE);

        // signed slt, swapped operands, write to $0 discarded
        set_reg(5'd1, 32'hFFFF_FFFD);
        set_reg(5'd2, 32'd2);
        exec_rf(rtype(5'd1, 5'd2, 5'd3, 6'h2A), 1'b1, 2'b00, 2'b10, 2'b01);
        read_reg("slt_lt", 5'd3, 32'd1);
        exec_rf(rtype(5'd2, 5'd1, 5'd3, 6'h2A), 1'b1, 2'b00, 2'b10, 2'b01);
        read_reg("slt_ge", 5'd3, 32'd0);
        exec_rf(rtype(5'd1, 5'd2, 5'd0, 6'h2A), 1'b1, 2'b00, 2'b10, 2'b01);
        read_reg("r0_zero", 5'd0, 32'd0);

        // sw then lw at 0x40
        set_reg(5'd5, 32'hDEAD_BEEF);
        load_ir(itype(6'h2B, 5'd0, 5'd5, 16'h0040));
        c = idle(); c.alusrc_a = 1'b1; c.alusrc_b = 2'b10;
        apply(c, 32'd0); tick();
        c = idle(); c.iord = 1'b1; c.memwrite = 1'b1;
        apply(c, 32'd0);
        check("sw_addr",  mem_addr,        32'h0000_0040);
        check("sw_wdata", mem_wdata,       32'hDEAD_BEEF);
        check("sw_write", 32'(mem_write),  32'd1);
        tick();
        c = idle(); c.alusrc_a = 1'b1; c.alusrc_b = 2'b10;
        apply(c, 32'd0); tick();
        c = idle(); c.iord = 1'b1; c.memread = 1'b1;
        apply(c, 32'h1234_5678);
        check("lw_addr", mem_addr, 32'h0000_0040);
        tick();
        c = idle(); c.regwrite = 1'b1; c.memtoreg = 2'b01;
        apply(c, 32'd0); tick();
        read_reg("lw_data", 5'd5, 32'h1234_5678);

        // Branches
        set_reg(5'd6, 32'd7);
        set_reg(5'd7, 32'd7);
        set_reg(5'd8, 32'd8);
        branch("beq_taken",  5'd6, 5'd7, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
        branch("bne_eq",     5'd6, 5'd7, 1'b0, 1'b1, 1'b1, 32'h0000_0004);
        branch("bne_taken",  5'd6, 5'd8, 1'b0, 1'b1, 1'b0, 32'h0000_0100);
        branch("beq_bne",    5'd6, 5'd8, 1'b1, 1'b1, 1'b0, 32'h0000_0100);

        // jal 0x40 from PC=8, then jr $ra
        set_pc(32'd8);
        c = idle(); c.ir_write = 1'b1;
        apply(c, {6'b000011, 26'h000_0040}); tick();
        c = idle(); c.pc_write = 1'b1; c.pcsrc = 2'b01; c.regdst = 2'b10;
        c.memtoreg = 2'b10; c.regwrite = 1'b1;
        apply(c, 32'd0); tick();
        peek_pc("jal_pc", 32'h0000_0100);
        read_reg("jal_ra", 5'd31, 32'd8);
        load_ir(rtype(5'd31, 5'd0, 5'd0, 6'h08));
        c = idle(); c.pc_write = 1'b1; c.pcsrc = 2'b11;
        apply(c, 32'd0); tick();
        peek_pc("jr_pc", 32'd8);

        // Reset during a register write
        c = idle(); c.regwrite = 1'b1; c.regdst = 2'b10; c.memtoreg = 2'b10; c.rst = 1'b1;
        apply(c, 32'd0); tick();
        peek_pc("midrst_pc", RESET_PC);
        read_reg("midrst_ra", 5'd31, 32'd0);
        read_reg("midrst_r5", 5'd5, 32'd0);

        // Random control and memory traffic against the model
        for (int i = 0; i < 800; i++) begin
            c.rst      = ($urandom_range(63) == 0);
            c.alusrc_a = 1'($urandom);
            c.alusrc_b = 2'($urandom);
            c.aluctrl  = 2'($urandom);
            c.memread  = 1'($urandom);
            c.memwrite = 1'($urandom);
            c.regwrite = 1'($urandom);
            c.pc_write = 1'($urandom);
            c.beq      = 1'($urandom);
            c.bne      = 1'($urandom);
            c.iord     = 1'($urandom);
            c.ir_write = 1'($urandom);
            c.pcsrc    = 2'($urandom);
            c.regdst   = 2'($urandom);
            c.memtoreg = 2'($urandom);
            apply(c, $urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Datapath for the multicycle MIPS-subset CPU; the consumer of every control strobe the multicycle controller issues.
- Returns opcode and zero to the controller.
- Holds the architectural and inter-cycle state: PC, IR, MDR, A, B, ALUOut and a 32x32 register file.
- Drives a single unified instruction/data memory port with combinational read and synchronous write.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state
alusrcA  in  1  ALU operand A select
alusrcB  in  2  ALU operand B select
toaluctrl  in  2  ALU operation class
memread  in  1  memory read strobe, forwarded to mem_read
memwrite  in  1  memory write strobe, forwarded to mem_write
regwrite  in  1  register file write enable
pc_write  in  1  unconditional PC write
pc_write_condition_beq  in  1  PC write if zero=1
pc_write_condition_bne  in  1  PC write if zero=0
IorD  in  1  memory address select: 0 PC, 1 ALUOut
IR_write  in  1  IR load enable
pcsrc  in  2  next-PC select
regdst  in  2  write-register select
memtoreg  in  2  write-data select
opcode  out  6  IR[31:26]
zero  out  1  combinational ALU result == 0
mem_addr  out  32  memory address
mem_wdata  out  32  store data, always B register
mem_rdata  in  32  memory read data, valid combinationally
mem_read  out  1  = memread
mem_write  out  1  = memwrite

Behaviour:
- Reset (synchronous, reset=1 at edge):
  - PC<=RESET_PC.
  - IR, MDR, A, B, ALUOut <= 0.
  - All 32 registers <= 0.
  - Hence opcode=0 and zero=1 after reset (ALU computes PC+0 with alusrcB=00, B=0 only if PC=0; zero is purely combinational).
  - Reset overrides every enable in the same cycle, including reset asserted mid-instruction.
- Unconditional per-cycle latches (no enable):
  - MDR<=mem_rdata.
  - A<=RF[IR[25:21]], B<=RF[IR[20:16]].
  - ALUOut<=ALU result.
- IR<=mem_rdata only when IR_write=1.
- ALU operand A: alusrcA=0 -> PC; 1 -> A.
- ALU operand B:
  - 00 -> B.
  - 01 -> 32'd4 when alusrcA=0; the immediate when alusrcA=1. Immediate is zero-extended if opcode=6'b001100 (andi), sign-extended otherwise.
  - 10 -> signext(IR[15:0]).
  - 11 -> signext(IR[15:0])<<2.
- ALU operation:
  - toaluctrl 00 add, 01 sub, 11 and.
  - toaluctrl 10 decodes funct IR[5:0]: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 signed slt (result 1/0). Any other funct -> add.
  - All arithmetic is 32-bit wrap-around; no overflow trap.
- Next PC by pcsrc:
  - 00 ALU result (combinational).
  - 01 {PC[31:28],IR[25:0],2'b00}.
  - 10 ALUOut.
  - 11 A.
- PC write enable = pc_write | (pc_write_condition_beq & zero) | (pc_write_condition_bne & ~zero).
  - beq and bne asserted together: PC always written.
- Write register by regdst: 00 IR[20:16], 01 IR[15:11], 10 5'd31, 11 IR[20:16].
- Write data by memtoreg: 00 ALUOut, 01 MDR, 10 PC, 11 ALUOut.
  - For jal with pcsrc=01 in the same cycle, the PC value written is the pre-update (already incremented) PC.
- Register file:
  - Asynchronous read; write on rising edge when regwrite=1.
  - Writes to register 0 are discarded; reads of register 0 return 0.
  - A read and a write to the same register in the same cycle: A/B capture the old value.
- Memory port:
  - mem_addr = IorD ? ALUOut : PC.
  - mem_wdata = B.
  - mem_read/mem_write are pure pass-through; no registering, no added latency.
- zero is combinational from the current-cycle ALU result, not from ALUOut.

Test Plan:
- Reset, fetch: reset 1 cycle, mem_rdata=32'h2008_0005 (addi $8,$0,5), assert IR_write, alusrcB=01, pc_write -> PC=4, opcode=6'b001000, mem_addr was 0 during fetch.
- addi/andi immediate: RF[9]=32'h0000_FFFF, IR=andi $10,$9,0x8001, alusrcA=1, alusrcB=01, toaluctrl=11, then regdst=00, regwrite -> RF[10]=32'h0000_8001 (zero-extended). Same setup with addi imm 0xFFFF -> RF[10]=32'h0000_FFFE.
- R-type slt: RF[1]=-3, RF[2]=2, funct 101010, toaluctrl=10, regdst=01 rd=3 -> RF[3]=1. Swapping operands -> RF[3]=0. Write with rd=0 -> RF[0] stays 0.
- lw/sw: B=32'hDEAD_BEEF, ALUOut=32'h40, IorD=1, memwrite -> mem_addr=32'h40, mem_wdata=32'hDEAD_BEEF, mem_write=1. Next, mem_rdata=32'h1234_5678, memtoreg=01, regwrite to rt -> RF[rt]=32'h1234_5678.
- Branches: A=B=7, ALUOut=32'h100, beq strobe, toaluctrl=01, pcsrc=10 -> zero=1, PC=32'h100. Same with bne -> PC unchanged. With A=7, B=8, bne -> PC=32'h100.
- jal/jr and mid-op reset: PC=32'h8, IR=jal 0x40, pcsrc=01, pc_write, regdst=10, memtoreg=10, regwrite -> PC=32'h100, RF[31]=32'h8. Then jr with A=32'h8, pcsrc=11 -> PC=32'h8. Reset asserted during a regwrite cycle -> RF[31]=0, PC=RESET_PC.
